// File: rtl/m_flit_inbuf.sv
`default_nettype none
// ============================================================================
// m_flit_inbuf : FWFT ingress flit buffer with head..tail framing for m_download.
// Optional M_INBUF_STATS_EN builds the pkt_cnt/drop_cnt statistics counters.
// Revision 1.0
// ============================================================================
module m_flit_inbuf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] flit_in,
   input  logic [1:0]  ctrl_in,
   input  logic        v_flit_in,
   output logic        ready_out,
   input  logic [1:0]  m_download_state,
   output logic [15:0] IN_flit_mem,
   output logic [1:0]  In_flit_ctrl,
   output logic        v_IN_flit_mem,
   output logic        err_frame,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  drop_cnt
);
   localparam logic [1:0]  c_HEAD  = 2'b01;
   localparam logic [1:0]  c_BODY  = 2'b10;
   localparam logic [1:0]  c_TAIL  = 2'b11;
   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
   localparam logic [3:0]  c_FMAX  = 4'd10;

   typedef enum logic [0:0] {F_IDLE = 1'b0, F_PKT = 1'b1} t_fstate;

   logic [17:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   t_fstate       r_state;
   logic [3:0]    r_fcnt;

   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_accept;
   logic [1:0]    w_hctrl;
   logic [15:0]   w_hdata;
   logic          w_v;
   logic [15:0]   w_odata;
   logic [1:0]    w_octrl;
   logic          w_err;
   logic          w_pkt_inc;
   logic          w_drop_inc;
   t_fstate       w_state_nxt;
   logic [3:0]    w_fcnt_nxt;

   assign w_empty   = (r_count == '0);
   assign ready_out = rst && (r_count < c_DEPTH);
   assign w_push    = v_flit_in && ready_out;
   assign w_accept  = (m_download_state == 2'b00) || (m_download_state == 2'b01);
   assign {w_hctrl, w_hdata} = r_mem[r_rd_ptr];

   // Forwarding decision for the head entry; everything is zero while in reset or empty.
   always_comb begin
      w_pop       = 1'b0;
      w_v         = 1'b0;
      w_odata     = '0;
      w_octrl     = '0;
      w_err       = 1'b0;
      w_pkt_inc   = 1'b0;
      w_drop_inc  = 1'b0;
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      if (rst && !w_empty) begin
         w_odata = w_hdata;
         w_octrl = w_hctrl;
         if (r_state == F_IDLE) begin
            if (w_hctrl == c_HEAD) begin
               if (w_accept) begin
                  w_v         = 1'b1;
                  w_pop       = 1'b1;
                  w_fcnt_nxt  = 4'd1;
                  w_state_nxt = F_PKT;
               end
            end else begin
               w_pop      = 1'b1;
               w_err      = 1'b1;
               w_drop_inc = 1'b1;
            end
         end else begin
            case (w_hctrl)
               c_BODY: begin
                  if (w_accept) begin
                     w_v   = 1'b1;
                     w_pop = 1'b1;
                     if (r_fcnt < c_FMAX) begin
                        w_fcnt_nxt = r_fcnt + 4'd1;
                     end else begin
                        w_octrl     = c_TAIL;
                        w_state_nxt = F_IDLE;
                        w_err       = 1'b1;
                        w_pkt_inc   = 1'b1;
                     end
                  end
               end
               c_TAIL: begin
                  if (w_accept) begin
                     w_v         = 1'b1;
                     w_pop       = 1'b1;
                     w_state_nxt = F_IDLE;
                     w_pkt_inc   = 1'b1;
                  end
               end
               c_HEAD: begin
                  // Close the open packet with a synthetic tail; the head stays queued.
                  if (w_accept) begin
                     w_v         = 1'b1;
                     w_odata     = '0;
                     w_octrl     = c_TAIL;
                     w_state_nxt = F_IDLE;
                     w_err       = 1'b1;
                     w_pkt_inc   = 1'b1;
                  end
               end
               default: begin
                  w_pop      = 1'b1;
                  w_err      = 1'b1;
                  w_drop_inc = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {ctrl_in, flit_in};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= F_IDLE;
         r_fcnt   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

`ifdef M_INBUF_STATS_EN
   logic [15:0] r_pkt_cnt;
   logic [7:0]  r_drop_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_pkt_inc) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
         if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign pkt_cnt  = r_pkt_cnt;
   assign drop_cnt = r_drop_cnt;
`else
   logic w_unused_stats;
   assign w_unused_stats = w_pkt_inc ^ w_drop_inc;
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
`endif

   assign v_IN_flit_mem = w_v;
   assign IN_flit_mem   = w_odata;
   assign In_flit_ctrl  = w_octrl;
   assign err_frame     = w_err;

endmodule
`default_nettype wire

// File: tb/tb_m_flit_inbuf.sv
`default_nettype none
// ============================================================================
// tb_m_flit_inbuf : vector table, corner sequences and random traffic vs a queue model.
// Revision 1.0
// ============================================================================
module tb_m_flit_inbuf;
   logic        clk;
   logic        rst;
   logic [15:0] flit_in;
   logic [1:0]  ctrl_in;
   logic        v_flit_in;
   logic        ready_out;
   logic [1:0]  m_download_state;
   logic [15:0] IN_flit_mem;
   logic [1:0]  In_flit_ctrl;
   logic        v_IN_flit_mem;
   logic        err_frame;
   logic [15:0] pkt_cnt;
   logic [7:0]  drop_cnt;

   m_flit_inbuf dut (
      .clk              (clk),
      .rst              (rst),
      .flit_in          (flit_in),
      .ctrl_in          (ctrl_in),
      .v_flit_in        (v_flit_in),
      .ready_out        (ready_out),
      .m_download_state (m_download_state),
      .IN_flit_mem      (IN_flit_mem),
      .In_flit_ctrl     (In_flit_ctrl),
      .v_IN_flit_mem    (v_IN_flit_mem),
      .err_frame        (err_frame),
      .pkt_cnt          (pkt_cnt),
      .drop_cnt         (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: queue of {ctrl,data}, packet-open flag and flits forwarded in the packet.
   logic [17:0] mq[$];
   bit          m_inpkt = 0;
   int          m_len   = 0;
   int          m_pkt   = 0;
   int          m_drop  = 0;

   logic        s_v, s_err, s_ready;
   logic [1:0]  s_ctrl;
   logic [15:0] s_data;

   typedef struct {
      logic        rn;
      logic        vi;
      logic [1:0]  ci;
      logic [15:0] di;
      logic [1:0]  st;
      logic        e_ready;
      logic        e_v;
      logic [1:0]  e_ctrl;
      logic [15:0] e_data;
      logic        e_err;
      logic        dchk;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic addv(input logic rn, input logic vi, input logic [1:0] ci, input logic [15:0] di,
                       input logic [1:0] st, input logic er, input logic ev, input logic [1:0] ec,
                       input logic [15:0] ed, input logic ee, input logic dc);
      vec_t v;
      v.rn = rn; v.vi = vi; v.ci = ci; v.di = di; v.st = st;
      v.e_ready = er; v.e_v = ev; v.e_ctrl = ec; v.e_data = ed; v.e_err = ee; v.dchk = dc;
      vt.push_back(v);
   endtask

   // One clock cycle: drive inputs, check outputs against the model mid-cycle, advance the model.
   task automatic tick(input logic rn, input logic vi, input logic [1:0] ci, input logic [15:0] di,
                       input logic [1:0] st);
      logic        e_ready, e_v, e_err, do_pop, acc, dchk, n_inpkt, pkt_ev, drop_ev;
      logic [1:0]  e_ctrl;
      logic [15:0] e_data, e_pkt;
      logic [7:0]  e_drop;
      logic [17:0] h;
      int          n_len;
      rst = rn; v_flit_in = vi; ctrl_in = ci; flit_in = di; m_download_state = st;
      @(negedge clk);
      #1;
      e_ready = rn && (mq.size() < 16);
      e_v = 0; e_ctrl = 0; e_data = 0; e_err = 0; do_pop = 0; dchk = 1;
      pkt_ev = 0; drop_ev = 0; n_inpkt = m_inpkt; n_len = m_len;
      acc = (st == 2'b00) || (st == 2'b01);
      if (rn && mq.size() != 0) begin
         h = mq[0];
         if (!m_inpkt) begin
            if (h[17:16] == 2'b01) begin
               if (acc) begin
                  e_v = 1; e_ctrl = 2'b01; e_data = h[15:0]; do_pop = 1; n_inpkt = 1; n_len = 1;
               end
            end else begin
               do_pop = 1; e_err = 1; drop_ev = 1;
            end
         end else begin
            case (h[17:16])
               2'b10: if (acc) begin
                  e_v = 1; e_data = h[15:0]; do_pop = 1; n_len = m_len + 1;
                  if (n_len == 11) begin
                     e_ctrl = 2'b11; e_err = 1; n_inpkt = 0; pkt_ev = 1;
                  end else begin
                     e_ctrl = 2'b10;
                  end
               end
               2'b11: if (acc) begin
                  e_v = 1; e_data = h[15:0]; e_ctrl = 2'b11; do_pop = 1; n_inpkt = 0; pkt_ev = 1;
               end
               2'b01: if (acc) begin
                  e_v = 1; e_data = 16'h0000; e_ctrl = 2'b11; e_err = 1; n_inpkt = 0; pkt_ev = 1;
               end
               default: begin
                  do_pop = 1; e_err = 1; drop_ev = 1;
               end
            endcase
         end
         dchk = e_v;
      end
      s_v = v_IN_flit_mem; s_err = err_frame; s_ready = ready_out;
      s_ctrl = In_flit_ctrl; s_data = IN_flit_mem;
      chk("ready_out", ready_out, e_ready);
      chk("v_IN_flit_mem", v_IN_flit_mem, e_v);
      chk("err_frame", err_frame, e_err);
      if (dchk) begin
         chk("IN_flit_mem", IN_flit_mem, e_data);
         chk("In_flit_ctrl", In_flit_ctrl, e_ctrl);
      end
`ifdef M_INBUF_STATS_EN
      e_pkt  = 16'(m_pkt);
      e_drop = 8'(m_drop);
`else
      e_pkt  = 16'h0;
      e_drop = 8'h0;
`endif
      if (rn) begin
         chk("pkt_cnt", pkt_cnt, e_pkt);
         chk("drop_cnt", drop_cnt, e_drop);
      end
      @(posedge clk);
      if (!rn) begin
         mq.delete(); m_inpkt = 0; m_len = 0; m_pkt = 0; m_drop = 0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (vi && e_ready) mq.push_back({ci, di});
         m_inpkt = n_inpkt; m_len = n_len;
         if (pkt_ev) m_pkt = (m_pkt + 1) % 65536;
         if (drop_ev && m_drop < 255) m_drop = m_drop + 1;
      end
      #1;
   endtask

   initial begin
      int errs;
      logic [15:0] tail_data;
      logic [1:0]  rc;
      int          r;
      rst = 0; v_flit_in = 0; ctrl_in = 0; flit_in = 0; m_download_state = 0;
      @(posedge clk);
      #1;

      // Reset with a push attempt, then basic packet (T1).
      addv(0,1,2'b01,16'h1234,2'b00, 0,0,2'b00,16'h0000,0,1);
      addv(0,1,2'b01,16'h1234,2'b00, 0,0,2'b00,16'h0000,0,1);
      addv(1,1,2'b01,16'h1000,2'b00, 1,0,2'b00,16'h0000,0,1);
      for (int i = 1; i <= 10; i++)
         addv(1,1,(i == 10) ? 2'b11 : 2'b10,16'(16'h1000 + i),2'b00,
              1,1,(i == 1) ? 2'b01 : 2'b10,16'(16'h1000 + i - 1),0,1);
      addv(1,0,2'b00,16'h0000,2'b00, 1,1,2'b11,16'h100A,0,1);
      addv(1,0,2'b00,16'h0000,2'b10, 1,0,2'b00,16'h0000,0,1);
      // Stray body while idle (T3).
      addv(1,1,2'b10,16'h00AA,2'b10, 1,0,2'b00,16'h0000,0,1);
      addv(1,0,2'b00,16'h0000,2'b10, 1,0,2'b00,16'h0000,1,0);
      addv(1,0,2'b00,16'h0000,2'b00, 1,0,2'b00,16'h0000,0,1);
      // Missing tail (T4).
      addv(1,1,2'b01,16'h2000,2'b00, 1,0,2'b00,16'h0000,0,1);
      addv(1,1,2'b10,16'h2001,2'b00, 1,1,2'b01,16'h2000,0,1);
      addv(1,1,2'b10,16'h2002,2'b00, 1,1,2'b10,16'h2001,0,1);
      addv(1,1,2'b01,16'h3000,2'b00, 1,1,2'b10,16'h2002,0,1);
      addv(1,0,2'b00,16'h0000,2'b00, 1,1,2'b11,16'h0000,1,1);
      addv(1,0,2'b00,16'h0000,2'b10, 1,0,2'b00,16'h0000,0,0);
      addv(1,0,2'b00,16'h0000,2'b00, 1,1,2'b01,16'h3000,0,1);
      addv(1,0,2'b00,16'h0000,2'b00, 1,0,2'b00,16'h0000,0,1);

      foreach (vt[i]) begin
         tick(vt[i].rn, vt[i].vi, vt[i].ci, vt[i].di, vt[i].st);
         chk($sformatf("tbl%0d_ready", i), s_ready, vt[i].e_ready);
         chk($sformatf("tbl%0d_v", i), s_v, vt[i].e_v);
         chk($sformatf("tbl%0d_err", i), s_err, vt[i].e_err);
         if (vt[i].dchk) begin
            chk($sformatf("tbl%0d_data", i), s_data, vt[i].e_data);
            chk($sformatf("tbl%0d_ctrl", i), s_ctrl, vt[i].e_ctrl);
         end
      end

      // Reset mid-packet with 4 flits buffered (T6).
      tick(1,1,2'b01,16'h6000,2'b10);
      for (int i = 1; i <= 3; i++) tick(1,1,2'b10,16'(16'h6000 + i),2'b10);
      tick(0,1,2'b10,16'h6004,2'b00);
      chk("t6_rst_ready", s_ready, 1'b0);
      chk("t6_rst_v", s_v, 1'b0);
      chk("t6_rst_data", {s_ctrl, s_data}, 18'h0);
      tick(1,0,2'b00,16'h0000,2'b00);
      chk("t6_post_v", s_v, 1'b0);
      chk("t6_post_ready", s_ready, 1'b1);
      chk("t6_post_pkt", pkt_cnt, 16'h0);
      chk("t6_post_drop", drop_cnt, 8'h0);
      tick(1,1,2'b10,16'h6100,2'b00);
      tick(1,0,2'b00,16'h0000,2'b00);
      chk("t6_idle_err", s_err, 1'b1);
      chk("t6_idle_v", s_v, 1'b0);

      // Full FIFO with m_download stalled (T2).
      tick(1,1,2'b01,16'h7000,2'b10);
      for (int i = 1; i <= 15; i++) tick(1,1,2'b10,16'(16'h7000 + i),2'b10);
      tick(1,1,2'b11,16'h7010,2'b10);
      chk("t2_full_ready", s_ready, 1'b0);
      tick(1,1,2'b11,16'h7010,2'b00);
      chk("t2_firstpop_ready", s_ready, 1'b0);
      chk("t2_firstpop_v", s_v, 1'b1);
      tick(1,1,2'b11,16'h7010,2'b00);
      chk("t2_after_pop_ready", s_ready, 1'b1);
      for (int i = 0; i < 24; i++) tick(1,0,2'b00,16'h0000,2'b00);

      // Overlong packet (T5).
      errs = 0;
      tail_data = 16'hFFFF;
      tick(1,1,2'b01,16'h5000,2'b00);
      for (int i = 1; i <= 15; i++) begin
         if (i <= 11) tick(1,1,2'b10,16'(16'h5000 + i),2'b00);
         else tick(1,0,2'b00,16'h0000,2'b00);
         if (s_err) errs++;
         if (s_v && s_ctrl == 2'b11) tail_data = s_data;
      end
      chk("t5_err_pulses", errs, 2);
      chk("t5_forced_tail", tail_data, 16'h500A);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         rc = (r < 20) ? 2'b01 : (r < 78) ? 2'b10 : (r < 95) ? 2'b11 : 2'b00;
         tick(($urandom_range(0, 149) != 0),
              ($urandom_range(0, 3) != 0),
              rc,
              16'($urandom),
              ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
